hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 63 ++++++
 rtl/hazard_if.sv | 48 ++++
 rtl/hazard_cmp.sv | 19 +
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the hazard / pipeline-control unit.
package hazard_pkg;

    localparam int ZERO_REG_DEF = 31;
    localparam int WCNT_W       = 3;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    function automatic ctrl_t ctrl_pass();
        ctrl_t c;
        c              = '0;
        c.pc_en        = 1'b1;
        c.if_id_en     = 1'b1;
        c.id_ex_en     = 1'b1;
        c.ex_mem_en    = 1'b1;
        c.mem_wb_en    = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_freeze();
        return '0;
    endfunction

    // Flush keeps the PC enabled so the branch target is loaded.
    function automatic ctrl_t ctrl_flush();
        ctrl_t c;
        c              = ctrl_pass();
        c.if_id_flush  = 1'b1;
        c.id_ex_flush  = 1'b1;
        c.ex_mem_flush = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_stall();
        ctrl_t c;
        c              = ctrl_pass();
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_bubble = 1'b1;
        return c;
    endfunction

    // The load's first freeze cycle is spent in RUN, so WAIT needs MEM_LAT-2 more.
    function automatic logic [WCNT_W-1:0] wcnt_load(int mem_lat);
        return (mem_lat > 1) ? WCNT_W'(mem_lat - 2) : '0;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side signals seen and driven by the hazard / pipeline-control unit.
interface hazard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic             mem_memread;
    logic             branch_taken;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2,
        output ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, mem_memread, branch_taken,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
        input  busy, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2,
        input  ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, mem_memread, branch_taken,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output id_ex_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
        output busy, stall_cnt
    );

endinterface

// File: rtl/hazard_cmp.sv
// RAW match between one older destination and one ID source; the zero register never matches.
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic             use_i,
    input  logic             regwrite_i,
    output logic             match_o
);

    localparam logic [REG_W-1:0] ZERO_ID = REG_W'(ZERO_REG);

    assign match_o = use_i && regwrite_i && (rd_i == rs_i) && (rd_i != ZERO_ID);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit: load-use / RAW stalls, branch flush and
// multi-cycle load freeze for the five-stage core.
//
//   state | meaning
//   RUN   | normal flow; a load in MEM freezes this cycle when MEM_LAT > 1
//   WAIT  | remaining load latency; freeze while wcnt != 0, release at 0
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter bit FWD_EN   = 1'b1,
    parameter int MEM_LAT  = 1,
    parameter int CNT_W    = 16
) (
    input logic     clk,
    input logic     reset,
    hazard_if.slave bus
);

    localparam bit                LOAD_FREEZES = (MEM_LAT > 1);
    localparam logic [WCNT_W-1:0] WCNT_LOAD    = wcnt_load(MEM_LAT);

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               freeze;
    logic               ex_m1, ex_m2, mem_m1, mem_m2;
    logic               hazard;
    ctrl_t              ctrl;

    hazard_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_ex1 (
        .rd_i       (bus.ex_rd),
        .rs_i       (bus.id_rs1),
        .use_i      (bus.id_use1),
        .regwrite_i (bus.ex_regwrite),
        .match_o    (ex_m1)
    );

    hazard_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_ex2 (
        .rd_i       (bus.ex_rd),
        .rs_i       (bus.id_rs2),
        .use_i      (bus.id_use2),
        .regwrite_i (bus.ex_regwrite),
        .match_o    (ex_m2)
    );

    hazard_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_mem1 (
        .rd_i       (bus.mem_rd),
        .rs_i       (bus.id_rs1),
        .use_i      (bus.id_use1),
        .regwrite_i (bus.mem_regwrite),
        .match_o    (mem_m1)
    );

    hazard_cmp #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_cmp_mem2 (
        .rd_i       (bus.mem_rd),
        .rs_i       (bus.id_rs2),
        .use_i      (bus.id_use2),
        .regwrite_i (bus.mem_regwrite),
        .match_o    (mem_m2)
    );

    // With forwarding only a load in EX cannot be bypassed in time.
    assign hazard = FWD_EN ? (bus.ex_memread && (ex_m1 || ex_m2))
                           : (ex_m1 || ex_m2 || mem_m1 || mem_m2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        freeze  = 1'b0;
        case (state_q)
            RUN: begin
                if (LOAD_FREEZES && bus.mem_memread) begin
                    freeze  = 1'b1;
                    state_d = WAIT;
                    wcnt_d  = WCNT_LOAD;
                end
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    freeze = 1'b1;
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Reset gating keeps the pipeline free-running while reset is held,
    // even if a load is still presented in MEM.
    always_comb begin
        ctrl = ctrl_pass();
        if (reset) begin
            ctrl = ctrl_pass();
        end else if (freeze) begin
            ctrl = ctrl_freeze();
        end else if (bus.branch_taken) begin
            ctrl = ctrl_flush();
        end else if (hazard) begin
            ctrl = ctrl_stall();
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc_en        = ctrl.pc_en;
    assign bus.if_id_en     = ctrl.if_id_en;
    assign bus.id_ex_en     = ctrl.id_ex_en;
    assign bus.ex_mem_en    = ctrl.ex_mem_en;
    assign bus.mem_wb_en    = ctrl.mem_wb_en;
    assign bus.id_ex_bubble = ctrl.id_ex_bubble;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.ex_mem_flush = ctrl.ex_mem_flush;
    assign bus.busy         = (state_q == WAIT);
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: three hazard_ctrl configurations driven by common
// stimulus and compared against a timeline-based reference model.
module tb_hazard_ctrl;

    localparam int N = 3;
    localparam int A_FWD = 1, A_LAT = 4, A_CW = 16;
    localparam int B_FWD = 0, B_LAT = 1, B_CW = 2;
    localparam int C_FWD = 1, C_LAT = 2, C_CW = 4;
    localparam int FWD [N] = '{A_FWD, B_FWD, C_FWD};
    localparam int LAT [N] = '{A_LAT, B_LAT, C_LAT};
    localparam int CW  [N] = '{A_CW,  B_CW,  C_CW};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_if #(.REG_W(5), .CNT_W(A_CW)) ifa ();
    hazard_if #(.REG_W(5), .CNT_W(B_CW)) ifb ();
    hazard_if #(.REG_W(5), .CNT_W(C_CW)) ifc ();

    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FWD_EN(1'b1), .MEM_LAT(A_LAT), .CNT_W(A_CW))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FWD_EN(1'b0), .MEM_LAT(B_LAT), .CNT_W(B_CW))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    hazard_ctrl #(.REG_W(5), .ZERO_REG(31), .FWD_EN(1'b1), .MEM_LAT(C_LAT), .CNT_W(C_CW))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use1, id_use2, ex_regwrite, ex_memread;
    logic       mem_regwrite, mem_memread, branch_taken;

    int checks = 0;
    int errors = 0;

    // Model: the freeze of a load is a window on the cycle timeline.
    int          t = 0;
    bit          trig_v [N];
    int          trig_t [N];
    int          scnt   [N];
    logic [31:0] exp_ctrl [N];
    logic [31:0] exp_cnt  [N];
    bit          exp_trig [N];
    logic [31:0] obs_ctrl [N];
    logic [31:0] obs_cnt  [N];

    task automatic apply();
        ifa.id_rs1 = id_rs1; ifa.id_rs2 = id_rs2; ifa.id_use1 = id_use1; ifa.id_use2 = id_use2;
        ifa.ex_rd = ex_rd; ifa.ex_regwrite = ex_regwrite; ifa.ex_memread = ex_memread;
        ifa.mem_rd = mem_rd; ifa.mem_regwrite = mem_regwrite; ifa.mem_memread = mem_memread;
        ifa.branch_taken = branch_taken;
        ifb.id_rs1 = id_rs1; ifb.id_rs2 = id_rs2; ifb.id_use1 = id_use1; ifb.id_use2 = id_use2;
        ifb.ex_rd = ex_rd; ifb.ex_regwrite = ex_regwrite; ifb.ex_memread = ex_memread;
        ifb.mem_rd = mem_rd; ifb.mem_regwrite = mem_regwrite; ifb.mem_memread = mem_memread;
        ifb.branch_taken = branch_taken;
        ifc.id_rs1 = id_rs1; ifc.id_rs2 = id_rs2; ifc.id_use1 = id_use1; ifc.id_use2 = id_use2;
        ifc.ex_rd = ex_rd; ifc.ex_regwrite = ex_regwrite; ifc.ex_memread = ex_memread;
        ifc.mem_rd = mem_rd; ifc.mem_regwrite = mem_regwrite; ifc.mem_memread = mem_memread;
        ifc.branch_taken = branch_taken;
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; mem_memread = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic compute();
        for (int k = 0; k < N; k++) begin
            bit em1, em2, mm1, mm2, hz, bsy, frz, tr;
            logic [9:0] c;
            em1 = id_use1 && ex_regwrite && (ex_rd == id_rs1) && (ex_rd != 5'd31);
            em2 = id_use2 && ex_regwrite && (ex_rd == id_rs2) && (ex_rd != 5'd31);
            mm1 = id_use1 && mem_regwrite && (mem_rd == id_rs1) && (mem_rd != 5'd31);
            mm2 = id_use2 && mem_regwrite && (mem_rd == id_rs2) && (mem_rd != 5'd31);
            hz  = (FWD[k] != 0) ? (ex_memread && (em1 || em2)) : (em1 || em2 || mm1 || mm2);
            bsy = trig_v[k] && (t > trig_t[k]) && (t <= trig_t[k] + LAT[k] - 1);
            tr  = !reset && !bsy && mem_memread && (LAT[k] > 1);
            frz = tr || (trig_v[k] && (t < trig_t[k] + LAT[k] - 1));
            if (reset)             c = 10'b11111_0_000_0;
            else if (frz)          c = {9'b00000_0_000, bsy};
            else if (branch_taken) c = {9'b11111_0_111, bsy};
            else if (hz)           c = {9'b00111_1_000, bsy};
            else                   c = {9'b11111_0_000, bsy};
            exp_ctrl[k] = {22'd0, c};
            exp_trig[k] = tr;
            exp_cnt[k]  = reset ? 32'd0 : 32'(scnt[k]);
        end
    endtask

    task automatic sample();
        obs_ctrl[0] = {22'd0, ifa.pc_en, ifa.if_id_en, ifa.id_ex_en, ifa.ex_mem_en, ifa.mem_wb_en,
                       ifa.id_ex_bubble, ifa.if_id_flush, ifa.id_ex_flush, ifa.ex_mem_flush, ifa.busy};
        obs_ctrl[1] = {22'd0, ifb.pc_en, ifb.if_id_en, ifb.id_ex_en, ifb.ex_mem_en, ifb.mem_wb_en,
                       ifb.id_ex_bubble, ifb.if_id_flush, ifb.id_ex_flush, ifb.ex_mem_flush, ifb.busy};
        obs_ctrl[2] = {22'd0, ifc.pc_en, ifc.if_id_en, ifc.id_ex_en, ifc.ex_mem_en, ifc.mem_wb_en,
                       ifc.id_ex_bubble, ifc.if_id_flush, ifc.id_ex_flush, ifc.ex_mem_flush, ifc.busy};
        obs_cnt[0] = 32'(ifa.stall_cnt);
        obs_cnt[1] = 32'(ifb.stall_cnt);
        obs_cnt[2] = 32'(ifc.stall_cnt);
    endtask

    task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h (cycle %0d)", tag, k, obs, exp, t);
        end
    endtask

    task automatic check_all(string tag);
        compute();
        sample();
        for (int k = 0; k < N; k++) begin
            check({tag, ".ctrl"}, k, obs_ctrl[k], exp_ctrl[k]);
            check({tag, ".cnt"},  k, obs_cnt[k],  exp_cnt[k]);
        end
    endtask

    task automatic tick();
        compute();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                trig_v[k] = 1'b0;
                scnt[k]   = 0;
            end else begin
                if (exp_trig[k]) begin
                    trig_v[k] = 1'b1;
                    trig_t[k] = t;
                end
                if (!exp_ctrl[k][9] && scnt[k] < (1 << CW[k]) - 1) scnt[k]++;
            end
        end
        t++;
        @(negedge clk);
    endtask

    task automatic cycle(string tag);
        apply();
        #1;
        check_all(tag);
        tick();
    endtask

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0:       return 5'd3;
            1:       return 5'd5;
            2:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        for (int k = 0; k < N; k++) begin
            trig_v[k] = 1'b0; trig_t[k] = 0; scnt[k] = 0;
        end
        clear_in();
        reset = 1'b0;
        apply();
        #2 reset = 1'b1;
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        reset = 1'b0;
        cycle("idle");

        // Load-use on rs1 from EX.
        ex_rd = 5'd3; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs1 = 5'd3; id_use1 = 1'b1;
        cycle("load_use");
        clear_in();
        cycle("after_load_use");

        // Zero register never a hazard source.
        ex_rd = 5'd31; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs1 = 5'd31; id_use1 = 1'b1;
        cycle("zero_reg");
        clear_in();

        // MEM RAW on rs2: stalls only without forwarding.
        mem_rd = 5'd5; mem_regwrite = 1'b1; id_rs2 = 5'd5; id_use2 = 1'b1;
        cycle("mem_raw");
        clear_in();
        cycle("idle2");

        // Back-to-back loads in MEM.
        mem_memread = 1'b1;
        for (int i = 0; i < 6; i++) cycle("load_freeze");
        mem_memread = 1'b0;
        for (int i = 0; i < 4; i++) cycle("load_drain");

        // Branch flush overrides a load-use stall.
        ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1; id_rs2 = 5'd7; id_use2 = 1'b1;
        branch_taken = 1'b1;
        cycle("flush_vs_stall");
        clear_in();
        cycle("idle3");

        // Reset in the middle of the second freeze cycle.
        mem_memread = 1'b1;
        cycle("frz1");
        #1 check_all("frz2");
        reset = 1'b1;
        apply();
        #1 check_all("rst_async");
        tick();
        clear_in();
        cycle("rst_hold");
        reset = 1'b0;
        cycle("rst_release");
        sample();
        check("busy_after_rst", 0, obs_ctrl[0] & 32'd1, 32'd0);
        check("cnt_after_rst", 0, obs_cnt[0], 32'd0);

        // Saturation of the 2-bit counter.
        mem_rd = 5'd9; mem_regwrite = 1'b1; id_rs1 = 5'd9; id_use1 = 1'b1;
        for (int i = 0; i < 5; i++) cycle("sat_stall");
        clear_in();
        cycle("sat_idle");
        sample();
        check("cnt_saturated", 1, obs_cnt[1], 32'd3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            id_rs1 = rreg(); id_rs2 = rreg(); ex_rd = rreg(); mem_rd = rreg();
            id_use1 = 1'($urandom_range(0, 1)); id_use2 = 1'($urandom_range(0, 1));
            ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_memread = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 59) == 0);
            cycle("random");
        end
        reset = 1'b0;
        clear_in();
        cycle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
